mem_resp: RTL and testbench

- Multi-cycle, word-organised memory responder: the memory side of the CPU's shared instruction/data memory port.
- The CPU issues a request with a word address, byte enables and write data. This block accepts it, inserts a configurable number of wait states, commits the write or reads the word, then returns a one-cycle ready pulse with read data.
- Sits between the CPU core's IorD address mux / byte-enable logic and the physical storage array.

---
 rtl/mem_resp_pkg.sv | 27 ++
 rtl/mem_resp_if.sv | 25 ++
 rtl/mem_array.sv | 24 ++
 rtl/mem_resp.sv | 109 ++++++++++
 tb/tb_mem_resp.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: FSM encodings, request record
// and default geometry/latency.
package mem_resp_pkg;

    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] din;
    } req_t;

    // True when no bit above the implemented word-address range is set.
    function automatic logic addr_in_range(input logic [31:0] a, input int aw);
        return (a >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/mem_resp_if.sv
// CPU-side memory port bundle between the core (master) and the responder (slave).
interface mem_resp_if;
    // Handshake: req is sampled only while the responder is idle (busy = 0);
    // a request seen while busy is dropped, not queued. Each accepted request
    // produces exactly one single-cycle ready pulse carrying err/dout.
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] din;
    logic        busy;
    logic        ready;
    logic        err;
    logic [31:0] dout;

    modport master (
        output req, we, addr, be, din,
        input  busy, ready, err, dout
    );

    modport slave (
        input  req, we, addr, be, din,
        output busy, ready, err, dout
    );
endinterface

// File: rtl/mem_array.sv
// Word storage: synchronous per-byte write, asynchronous read. Not reset.
module mem_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_resp.sv
// Multi-cycle memory responder: accepts one request, waits WAIT_CYCLES,
// commits the write or reads the word, then pulses ready with dout/err.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic   clk,
    input  logic   rst,
    mem_resp_if.slave bus,
    output state_t dbg_state
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               lat_q, lat_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic [31:0]        dout_q, dout_d;

    req_t               c_req;
    logic               commit;
    logic               in_range;
    logic [3:0]         mem_be;
    logic [31:0]        mem_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        commit  = 1'b0;
        // With zero wait states the commit edge is the accept edge, so the
        // access must be taken straight from the port rather than the latch.
        if (state_q == S_IDLE) begin
            c_req = '{we: bus.we, addr: bus.addr, be: bus.be, din: bus.din};
        end else begin
            c_req = lat_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    lat_d = c_req;
                    cnt_d = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_range = addr_in_range(c_req.addr, ADDR_WIDTH);
        mem_be   = (commit && c_req.we && in_range) ? c_req.be : 4'b0000;
        ready_d  = commit;
        err_d    = commit && !in_range;
        dout_d   = dout_q;
        if (commit) begin
            dout_d = (!c_req.we && in_range) ? mem_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    mem_array #(.AW(ADDR_WIDTH)) u_mem (
        .clk   (clk),
        .wr_be (mem_be),
        .addr  (c_req.addr[ADDR_WIDTH-1:0]),
        .wdata (c_req.din),
        .rdata (mem_rdata)
    );

    assign bus.busy  = (state_q != S_IDLE);
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.dout  = dout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_resp.sv
// Directed + scoreboard bench for mem_resp with three latency variants (0, 1, 3 wait states).
module tb_mem_resp;
    import mem_resp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req, we;
    logic [31:0] addr, din;
    logic [3:0]  be;
    int          sel;

    logic        busy_s, ready_s, err_s;
    logic [31:0] dout_s;
    state_t      dbg0, dbg1, dbg3, dbg_s;

    logic [32:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    longint      last_ready_t;
    logic [31:0] ref_mem [16];

    mem_resp_if if0();
    mem_resp_if if1();
    mem_resp_if if3();

    assign if0.req = req && (sel == 0);
    assign if1.req = req && (sel == 1);
    assign if3.req = req && (sel == 3);
    assign if0.we = we;   assign if1.we = we;   assign if3.we = we;
    assign if0.addr = addr; assign if1.addr = addr; assign if3.addr = addr;
    assign if0.be = be;   assign if1.be = be;   assign if3.be = be;
    assign if0.din = din; assign if1.din = din; assign if3.din = din;

    mem_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst_n), .bus(if0), .dbg_state(dbg0));
    mem_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst_n), .bus(if1), .dbg_state(dbg1));
    mem_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst_n), .bus(if3), .dbg_state(dbg3));

    always_comb begin
        case (sel)
            0: begin busy_s = if0.busy; ready_s = if0.ready; err_s = if0.err; dout_s = if0.dout; dbg_s = dbg0; end
            1: begin busy_s = if1.busy; ready_s = if1.ready; err_s = if1.err; dout_s = if1.dout; dbg_s = dbg1; end
            default: begin busy_s = if3.busy; ready_s = if3.ready; err_s = if3.err; dout_s = if3.dout; dbg_s = dbg3; end
        endcase
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (observed running, required done)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction, entered and left at a falling edge. Pushes the expected
    // {err, dout}, then waits (bounded) for ready and compares.
    task automatic txn(input logic t_we, input logic [31:0] t_addr, input logic [3:0] t_be,
                       input logic [31:0] t_din, input logic exp_err, input logic [31:0] exp_dout,
                       input bit scramble, input bit poke);
        int n;
        logic [32:0] e;
        exp_q.push_back({exp_err, exp_dout});
        req = 1'b1; we = t_we; addr = t_addr; be = t_be; din = t_din;
        @(posedge clk);
        @(negedge clk);
        req = poke;
        if (scramble) begin
            we = 1'b1; addr = 32'd10; be = 4'hF; din = $urandom;
        end
        n = 1;
        while (!ready_s && n < 40) begin
            check("busy_wait", 64'(busy_s), 64'd1);
            @(negedge clk);
            n++;
            if (scramble) din = $urandom;
        end
        if (!ready_s) begin
            check("ready_timeout", 64'(ready_s), 64'd1);
            void'(exp_q.pop_front());
        end else begin
            check("latency", 64'(n), 64'(sel + 1));
            check("busy_resp", 64'(busy_s), 64'd1);
            e = exp_q.pop_front();
            check("resp_err_dout", 64'({err_s, dout_s}), 64'(e));
            last_ready_t = $time;
        end
        @(negedge clk);
        req = 1'b0;
        check("idle_after", 64'({ready_s, busy_s}), 64'd0);
    endtask

    task automatic quiet(input int cycles);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            saw = saw | ready_s;
        end
        check("no_extra_ready", 64'(saw), 64'd0);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] b, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    initial begin
        int sels[3];
        longint t0;
        logic [31:0] rd, rnd_din;
        logic [3:0] rnd_be;
        int ai;
        sels = '{0, 1, 3};
        n_checks = 0; n_fail = 0; last_ready_t = 0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; din = '0; sel = 0;

        // reset state of every variant
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = sels[s];
            #1;
            check("reset_outputs", 64'({busy_s, ready_s, err_s, dout_s}), 64'd0);
            check("reset_state", 64'(dbg_s), 64'(S_IDLE));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // one wait state: basic, partial bytes, out of range
        sel = 1;
        txn(1, 32'd5, 4'hF, 32'hDEADBEEF, 0, 32'd0, 0, 0);
        txn(0, 32'd5, 4'hF, 32'd0, 0, 32'hDEADBEEF, 0, 0);
        txn(1, 32'd7, 4'hF, 32'h11223344, 0, 32'd0, 0, 0);
        txn(1, 32'd7, 4'b0101, 32'hAABBCCDD, 0, 32'd0, 0, 0);
        txn(0, 32'd7, 4'h3, 32'd0, 0, 32'h11BB33DD, 0, 0);
        txn(1, 32'd7, 4'b0000, 32'hFFFFFFFF, 0, 32'd0, 0, 0);
        txn(0, 32'd7, 4'h0, 32'd0, 0, 32'h11BB33DD, 0, 0);
        txn(1, 32'd0, 4'hF, 32'h0BADF00D, 0, 32'd0, 0, 0);
        txn(0, 32'd0, 4'hF, 32'd0, 0, 32'h0BADF00D, 0, 0);
        txn(1, 32'h400, 4'hF, 32'h12345678, 1, 32'd0, 0, 0);
        txn(0, 32'd0, 4'hF, 32'd0, 0, 32'h0BADF00D, 0, 0);
        txn(0, 32'h400, 4'hF, 32'd0, 1, 32'd0, 0, 0);
        txn(0, 32'h80000005, 4'hF, 32'd0, 1, 32'd0, 0, 0);

        // inputs change after accept; req re-asserted while busy
        txn(1, 32'd10, 4'hF, 32'h10101010, 0, 32'd0, 0, 0);
        txn(1, 32'd9, 4'hF, 32'h55AA55AA, 0, 32'd0, 1, 0);
        txn(0, 32'd9, 4'hF, 32'd0, 0, 32'h55AA55AA, 0, 0);
        txn(0, 32'd10, 4'hF, 32'd0, 0, 32'h10101010, 0, 0);
        txn(0, 32'd9, 4'hF, 32'd0, 0, 32'h55AA55AA, 0, 1);
        quiet(6);

        // random byte-enable traffic against a reference model, words 16..31
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            txn(1, 32'(16 + i), 4'hF, ref_mem[i], 0, 32'd0, 0, 0);
        end
        for (int k = 0; k < 24; k++) begin
            ai = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                rnd_be = 4'($urandom_range(0, 15));
                rnd_din = $urandom;
                ref_mem[ai] = merge(ref_mem[ai], rnd_be, rnd_din);
                txn(1, 32'(16 + ai), rnd_be, rnd_din, 0, 32'd0, 0, 0);
            end else begin
                rd = ref_mem[ai];
                txn(0, 32'(16 + ai), 4'($urandom_range(0, 15)), 32'd0, 0, rd, 0, 0);
            end
        end

        // zero wait states: back-to-back reads two cycles apart
        sel = 0;
        txn(1, 32'd0, 4'hF, 32'hA0A0A0A0, 0, 32'd0, 0, 0);
        txn(1, 32'd1, 4'hF, 32'hB1B1B1B1, 0, 32'd0, 0, 0);
        txn(0, 32'd0, 4'hF, 32'd0, 0, 32'hA0A0A0A0, 0, 0);
        t0 = last_ready_t;
        txn(0, 32'd1, 4'hF, 32'd0, 0, 32'hB1B1B1B1, 0, 0);
        check("b2b_spacing", 64'(last_ready_t - t0), 64'd20);

        // three wait states: reset during WAIT aborts the write
        sel = 3;
        txn(1, 32'd2, 4'hF, 32'h01020304, 0, 32'd0, 0, 0);
        txn(0, 32'd2, 4'hF, 32'd0, 0, 32'h01020304, 0, 0);
        req = 1'b1; we = 1'b1; addr = 32'd2; be = 4'hF; din = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("busy_before_abort", 64'(busy_s), 64'd1);
        check("state_before_abort", 64'(dbg_s), 64'(S_WAIT));
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", 64'({busy_s, ready_s, err_s, dout_s}), 64'd0);
        check("abort_state", 64'(dbg_s), 64'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        quiet(6);
        txn(0, 32'd2, 4'hF, 32'd0, 0, 32'h01020304, 0, 0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
